// File: rtl/lift_overall.sv
// lift_overall: three-car, six-floor elevator group controller.
// Latches car and hall buttons and hands each hall call to one car.
// Each car runs its own motion/door state machine and drives one-hot commands.
module lift_overall #(
  parameter int FLOOR_TRAVEL_CYCLES = 10,
  parameter int DOOR_OPEN_CYCLES    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:1] emergency,
  input  logic [5:0] Car_call_signal1,
  input  logic [5:0] Car_call_signal2,
  input  logic [5:0] Car_call_signal3,
  input  logic [4:0] Hall_call_Up_signal,
  input  logic [5:1] Hall_call_Down_signal,
  output logic [3:1] MoveUp,
  output logic [3:1] MoveDown,
  output logic [3:1] OpenDoor,
  output logic [3:1] CloseDoor,
  output logic [3:1] Stop,
  output logic [2:0] LCD1,
  output logic [2:0] LCD2,
  output logic [2:0] LCD3,
  output logic [4:0] LED_HALL_UP,
  output logic [5:1] LED_HALL_DOWN,
  output logic [5:0] LED_Car1,
  output logic [5:0] LED_Car2,
  output logic [5:0] LED_Car3,
  output logic [8:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN, S_DOOR_CLOSE, S_EMERG
  } state_t;

  // one-hot command word: {stop, close, open, down, up}
  localparam logic [4:0] CMD_UP    = 5'b00001;
  localparam logic [4:0] CMD_DN    = 5'b00010;
  localparam logic [4:0] CMD_OPEN  = 5'b00100;
  localparam logic [4:0] CMD_CLOSE = 5'b01000;
  localparam logic [4:0] CMD_STOP  = 5'b10000;

  state_t      r_state  [1:3];
  state_t      r_saved  [1:3];
  logic [2:0]  r_floor  [1:3];
  logic [15:0] r_cnt    [1:3];
  logic        r_dir    [1:3];
  logic [4:0]  r_cmd    [1:3];
  logic [5:0]  r_car    [1:3];
  logic [4:0]  r_hup;
  logic [5:1]  r_hdn;
  logic [1:0]  r_own_up [0:4];
  logic [1:0]  r_own_dn [1:5];

  logic [5:0]  w_car_btn   [1:3];
  logic [5:0]  w_req       [1:3];
  state_t      w_eff       [1:3];
  logic        w_arrive    [1:3];
  logic [2:0]  w_nfloor    [1:3];
  logic        w_above     [1:3];
  logic        w_below     [1:3];
  logic        w_above_n   [1:3];
  logic        w_below_n   [1:3];
  logic        w_open      [1:3];
  logic [5:0]  w_clr_car   [1:3];
  logic [4:0]  w_clr_up;
  logic [5:1]  w_clr_dn;
  logic [9:0]  w_cand;
  logic [1:0]  w_asg       [0:9];

  function automatic logic f_bit(input logic [5:0] v, input logic [2:0] fl);
    f_bit = 1'b0;
    for (int i = 0; i < 6; i++) if (3'(i) == fl) f_bit = v[i];
  endfunction

  function automatic logic f_above(input logic [5:0] v, input logic [2:0] fl);
    f_above = 1'b0;
    for (int i = 0; i < 6; i++) if (3'(i) > fl) f_above = f_above | v[i];
  endfunction

  function automatic logic f_below(input logic [5:0] v, input logic [2:0] fl);
    f_below = 1'b0;
    for (int i = 0; i < 6; i++) if (3'(i) < fl) f_below = f_below | v[i];
  endfunction

  // Per-car request set, effective state (EMERG resumes its saved state) and stop decision
  always_comb begin
    w_car_btn[1] = Car_call_signal1;
    w_car_btn[2] = Car_call_signal2;
    w_car_btn[3] = Car_call_signal3;
    for (int c = 1; c <= 3; c++) begin
      w_req[c] = r_car[c];
      for (int f = 0; f < 5; f++) if (r_hup[f] && r_own_up[f] == 2'(c)) w_req[c][f] = 1'b1;
      for (int f = 1; f < 6; f++) if (r_hdn[f] && r_own_dn[f] == 2'(c)) w_req[c][f] = 1'b1;
      w_eff[c]    = (r_state[c] == S_EMERG) ? r_saved[c] : r_state[c];
      w_arrive[c] = (r_cnt[c] == 16'(FLOOR_TRAVEL_CYCLES - 1));
      w_nfloor[c] = r_floor[c];
      if (w_eff[c] == S_MOVE_UP)        w_nfloor[c] = r_floor[c] + 3'd1;
      else if (w_eff[c] == S_MOVE_DOWN) w_nfloor[c] = r_floor[c] - 3'd1;
      w_above[c]   = f_above(w_req[c], r_floor[c]);
      w_below[c]   = f_below(w_req[c], r_floor[c]);
      w_above_n[c] = f_above(w_req[c], w_nfloor[c]);
      w_below_n[c] = f_below(w_req[c], w_nfloor[c]);
      w_open[c]    = 1'b0;
      if (!emergency[c]) begin
        if (w_eff[c] == S_IDLE)
          w_open[c] = f_bit(w_req[c], r_floor[c]);
        else if ((w_eff[c] == S_MOVE_UP || w_eff[c] == S_MOVE_DOWN) && w_arrive[c])
          w_open[c] = f_bit(w_req[c], w_nfloor[c]);
      end
    end
  end

  // Calls serviced this cycle: the stopping car's own call and hall calls it owns at that floor
  always_comb begin
    w_clr_up = '0;
    w_clr_dn = '0;
    for (int c = 1; c <= 3; c++) begin
      w_clr_car[c] = '0;
      for (int f = 0; f < 6; f++)
        if (w_open[c] && w_nfloor[c] == 3'(f)) w_clr_car[c][f] = 1'b1;
      for (int f = 0; f < 5; f++)
        if (w_clr_car[c][f] && r_hup[f] && r_own_up[f] == 2'(c)) w_clr_up[f] = 1'b1;
      for (int f = 1; f < 6; f++)
        if (w_clr_car[c][f] && r_hdn[f] && r_own_dn[f] == 2'(c)) w_clr_dn[f] = 1'b1;
    end
  end

  // Hall-call dispatch in order up[0..4], down[1..5]; a car taken earlier this cycle is no longer idle-eligible
  always_comb begin
    logic [3:1] v_taken;
    logic [2:0] v_fc, v_d, v_bed, v_bad;
    logic [1:0] v_be, v_ba;
    logic       v_up, v_el;
    for (int f = 0; f < 5; f++) w_cand[f]   = (Hall_call_Up_signal[f] & ~r_hup[f]) | (r_hup[f] & (r_own_up[f] == 2'd0));
    for (int f = 1; f < 6; f++) w_cand[f+4] = (Hall_call_Down_signal[f] & ~r_hdn[f]) | (r_hdn[f] & (r_own_dn[f] == 2'd0));
    v_taken = '0;
    for (int k = 0; k < 10; k++) begin
      v_up  = (k < 5);
      v_fc  = v_up ? 3'(k) : 3'(k - 4);
      v_be  = 2'd0;
      v_ba  = 2'd0;
      v_bed = 3'd7;
      v_bad = 3'd7;
      for (int c = 1; c <= 3; c++) begin
        v_d  = (r_floor[c] >= v_fc) ? (r_floor[c] - v_fc) : (v_fc - r_floor[c]);
        v_el = (r_state[c] == S_IDLE && !v_taken[c]) ||
               (v_up && r_state[c] == S_MOVE_UP && r_floor[c] < v_fc) ||
               (!v_up && r_state[c] == S_MOVE_DOWN && r_floor[c] > v_fc);
        if (!emergency[c] && r_state[c] != S_EMERG) begin
          if (v_el && v_d < v_bed) begin v_be = 2'(c); v_bed = v_d; end
          if (v_d < v_bad)         begin v_ba = 2'(c); v_bad = v_d; end
        end
      end
      w_asg[k] = 2'd0;
      if (w_cand[k]) begin
        w_asg[k] = (v_be != 2'd0) ? v_be : v_ba;
        if (w_asg[k] != 2'd0) v_taken[w_asg[k]] = 1'b1;
      end
    end
  end

  // Button latching and hall-call ownership; servicing a call wins over a new press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hup <= '0;
      r_hdn <= '0;
      for (int c = 1; c <= 3; c++) r_car[c] <= '0;
      for (int f = 0; f < 5; f++) r_own_up[f] <= 2'd0;
      for (int f = 1; f < 6; f++) r_own_dn[f] <= 2'd0;
    end else begin
      for (int c = 1; c <= 3; c++) r_car[c] <= (r_car[c] | w_car_btn[c]) & ~w_clr_car[c];
      for (int f = 0; f < 5; f++) begin
        if (w_clr_up[f]) begin
          r_hup[f] <= 1'b0; r_own_up[f] <= 2'd0;
        end else begin
          if (Hall_call_Up_signal[f]) r_hup[f] <= 1'b1;
          if (w_asg[f] != 2'd0) r_own_up[f] <= w_asg[f];
        end
      end
      for (int f = 1; f < 6; f++) begin
        if (w_clr_dn[f]) begin
          r_hdn[f] <= 1'b0; r_own_dn[f] <= 2'd0;
        end else begin
          if (Hall_call_Down_signal[f]) r_hdn[f] <= 1'b1;
          if (w_asg[f+4] != 2'd0) r_own_dn[f] <= w_asg[f+4];
        end
      end
    end
  end

  // Per-car motion/door FSM with registered one-hot commands; emergency freezes floor and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 1; c <= 3; c++) begin
        r_state[c] <= S_IDLE;  r_saved[c] <= S_IDLE;
        r_floor[c] <= 3'd0;    r_cnt[c]   <= '0;
        r_dir[c]   <= 1'b1;    r_cmd[c]   <= CMD_STOP;
      end
    end else begin
      for (int c = 1; c <= 3; c++) begin
        if (emergency[c]) begin
          if (r_state[c] != S_EMERG) r_saved[c] <= r_state[c];
          r_state[c] <= S_EMERG;
          r_cmd[c]   <= CMD_STOP;
        end else begin
          case (w_eff[c])
            S_MOVE_UP, S_MOVE_DOWN: begin
              if (w_arrive[c]) begin
                r_floor[c] <= w_nfloor[c];
                r_cnt[c]   <= '0;
                if (w_open[c]) begin
                  r_state[c] <= S_DOOR_OPEN; r_cmd[c] <= CMD_OPEN;
                end else if (w_eff[c] == S_MOVE_UP ? w_above_n[c] : w_below_n[c]) begin
                  r_state[c] <= w_eff[c];
                  r_cmd[c]   <= (w_eff[c] == S_MOVE_UP) ? CMD_UP : CMD_DN;
                end else begin
                  r_state[c] <= S_IDLE; r_cmd[c] <= CMD_STOP;
                end
              end else begin
                r_cnt[c]   <= r_cnt[c] + 16'd1;
                r_state[c] <= w_eff[c];
                r_cmd[c]   <= (w_eff[c] == S_MOVE_UP) ? CMD_UP : CMD_DN;
              end
            end
            S_DOOR_OPEN: begin
              if (r_cnt[c] == 16'(DOOR_OPEN_CYCLES - 1)) begin
                r_cnt[c] <= '0; r_state[c] <= S_DOOR_CLOSE; r_cmd[c] <= CMD_CLOSE;
              end else begin
                r_cnt[c] <= r_cnt[c] + 16'd1; r_state[c] <= S_DOOR_OPEN; r_cmd[c] <= CMD_OPEN;
              end
            end
            default: begin
              // IDLE and DOOR_CLOSE: open here, else keep direction while requests lie ahead, else reverse
              r_cnt[c] <= '0;
              if (w_open[c]) begin
                r_state[c] <= S_DOOR_OPEN; r_cmd[c] <= CMD_OPEN;
              end else if (w_above[c] && (r_dir[c] || !w_below[c] || w_eff[c] == S_IDLE)) begin
                r_state[c] <= S_MOVE_UP; r_dir[c] <= 1'b1; r_cmd[c] <= CMD_UP;
              end else if (w_below[c]) begin
                r_state[c] <= S_MOVE_DOWN; r_dir[c] <= 1'b0; r_cmd[c] <= CMD_DN;
              end else begin
                r_state[c] <= S_IDLE; r_cmd[c] <= CMD_STOP;
              end
            end
          endcase
        end
      end
    end
  end

  // Output mapping from registered state
  always_comb begin
    for (int c = 1; c <= 3; c++)
      {Stop[c], CloseDoor[c], OpenDoor[c], MoveDown[c], MoveUp[c]} = r_cmd[c];
    LCD1          = r_floor[1];
    LCD2          = r_floor[2];
    LCD3          = r_floor[3];
    LED_HALL_UP   = r_hup;
    LED_HALL_DOWN = r_hdn;
    LED_Car1      = r_car[1];
    LED_Car2      = r_car[2];
    LED_Car3      = r_car[3];
    o_dbg_state   = {r_state[3], r_state[2], r_state[1]};
  end

endmodule

// File: tb/tb_lift_overall.sv
// Directed testbench for lift_overall: reset, single hall call, car call at floor,
// simultaneous dispatch, busy-car dispatch, emergency hold and dispatch, mid-run reset.
module tb_lift_overall;

  logic       clk;
  logic       rst_n;
  logic [3:1] emergency;
  logic [5:0] Car_call_signal1, Car_call_signal2, Car_call_signal3;
  logic [4:0] Hall_call_Up_signal;
  logic [5:1] Hall_call_Down_signal;
  logic [3:1] MoveUp, MoveDown, OpenDoor, CloseDoor, Stop;
  logic [2:0] LCD1, LCD2, LCD3;
  logic [4:0] LED_HALL_UP;
  logic [5:1] LED_HALL_DOWN;
  logic [5:0] LED_Car1, LED_Car2, LED_Car3;
  logic [8:0] o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  lift_overall #(.FLOOR_TRAVEL_CYCLES(10), .DOOR_OPEN_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .emergency(emergency),
    .Car_call_signal1(Car_call_signal1), .Car_call_signal2(Car_call_signal2),
    .Car_call_signal3(Car_call_signal3),
    .Hall_call_Up_signal(Hall_call_Up_signal), .Hall_call_Down_signal(Hall_call_Down_signal),
    .MoveUp(MoveUp), .MoveDown(MoveDown), .OpenDoor(OpenDoor), .CloseDoor(CloseDoor), .Stop(Stop),
    .LCD1(LCD1), .LCD2(LCD2), .LCD3(LCD3),
    .LED_HALL_UP(LED_HALL_UP), .LED_HALL_DOWN(LED_HALL_DOWN),
    .LED_Car1(LED_Car1), .LED_Car2(LED_Car2), .LED_Car3(LED_Car3),
    .o_dbg_state(o_dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    emergency = '0;
    Car_call_signal1 = '0; Car_call_signal2 = '0; Car_call_signal3 = '0;
    Hall_call_Up_signal = '0; Hall_call_Down_signal = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step(2);
    n_checks++; if (Stop !== 3'b111) begin n_errors++; $display("FAIL reset_stop: got %b exp 111", Stop); end
    n_checks++; if ({MoveUp, MoveDown, OpenDoor, CloseDoor} !== 12'd0) begin n_errors++; $display("FAIL reset_cmds: got %b exp 0", {MoveUp, MoveDown, OpenDoor, CloseDoor}); end
    n_checks++; if ({LCD1, LCD2, LCD3} !== 9'd0) begin n_errors++; $display("FAIL reset_lcd: got %h exp 0", {LCD1, LCD2, LCD3}); end
    n_checks++; if ({LED_HALL_UP, LED_HALL_DOWN, LED_Car1, LED_Car2, LED_Car3} !== 28'd0) begin n_errors++; $display("FAIL reset_leds: got %h exp 0", {LED_HALL_UP, LED_HALL_DOWN, LED_Car1, LED_Car2, LED_Car3}); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_hall();
    do_reset();
    Hall_call_Up_signal = 5'b00100;
    step(1); // edge k: latched, car 1 owns it
    n_checks++; if (LED_HALL_UP !== 5'b00100) begin n_errors++; $display("FAIL single_led: got %b exp 00100", LED_HALL_UP); end
    n_checks++; if (Stop !== 3'b111) begin n_errors++; $display("FAIL single_stop_k: got %b exp 111", Stop); end
    step(1); // k+1
    n_checks++; if (MoveUp !== 3'b001) begin n_errors++; $display("FAIL single_moveup: got %b exp 001", MoveUp); end
    step(1); // k+2, button held three edges
    Hall_call_Up_signal = '0;
    step(8); // k+10
    n_checks++; if (LCD1 !== 3'd0) begin n_errors++; $display("FAIL single_lcd_k10: got %0d exp 0", LCD1); end
    step(1); // k+11
    n_checks++; if (LCD1 !== 3'd1) begin n_errors++; $display("FAIL single_lcd_k11: got %0d exp 1", LCD1); end
    n_checks++; if (MoveUp !== 3'b001) begin n_errors++; $display("FAIL single_pass1: got %b exp 001", MoveUp); end
    step(10); // k+21
    n_checks++; if (LCD1 !== 3'd2) begin n_errors++; $display("FAIL single_lcd_k21: got %0d exp 2", LCD1); end
    n_checks++; if (OpenDoor !== 3'b001) begin n_errors++; $display("FAIL single_open: got %b exp 001", OpenDoor); end
    n_checks++; if (LED_HALL_UP !== 5'b00000) begin n_errors++; $display("FAIL single_led_clr: got %b exp 00000", LED_HALL_UP); end
    step(4); // k+25
    n_checks++; if (OpenDoor !== 3'b001) begin n_errors++; $display("FAIL single_open_last: got %b exp 001", OpenDoor); end
    step(1); // k+26
    n_checks++; if ({CloseDoor, OpenDoor} !== 6'b001000) begin n_errors++; $display("FAIL single_close: got %b exp 001000", {CloseDoor, OpenDoor}); end
    step(1); // k+27
    n_checks++; if (Stop !== 3'b111) begin n_errors++; $display("FAIL single_stop_end: got %b exp 111", Stop); end
    n_checks++; if ({LCD1, LCD2, LCD3} !== {3'd2, 3'd0, 3'd0}) begin n_errors++; $display("FAIL single_lcds: got %h exp %h", {LCD1, LCD2, LCD3}, {3'd2, 3'd0, 3'd0}); end
  endtask

  task automatic test_car_call_here();
    do_reset();
    Car_call_signal3 = 6'b000001;
    step(1); // k
    n_checks++; if (LED_Car3 !== 6'b000001) begin n_errors++; $display("FAIL here_led: got %b exp 000001", LED_Car3); end
    Car_call_signal3 = '0;
    step(1); // k+1
    n_checks++; if (OpenDoor !== 3'b100) begin n_errors++; $display("FAIL here_open: got %b exp 100", OpenDoor); end
    n_checks++; if (LED_Car3 !== 6'b000000) begin n_errors++; $display("FAIL here_led_clr: got %b exp 000000", LED_Car3); end
    n_checks++; if ({MoveUp, MoveDown} !== 6'd0) begin n_errors++; $display("FAIL here_nomove: got %b exp 0", {MoveUp, MoveDown}); end
    step(5); // k+6
    n_checks++; if (CloseDoor !== 3'b100) begin n_errors++; $display("FAIL here_close: got %b exp 100", CloseDoor); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    Hall_call_Up_signal = 5'b00011;
    step(1); // k
    n_checks++; if (LED_HALL_UP !== 5'b00011) begin n_errors++; $display("FAIL simul_led: got %b exp 00011", LED_HALL_UP); end
    Hall_call_Up_signal = '0;
    step(1); // k+1
    n_checks++; if (OpenDoor !== 3'b001) begin n_errors++; $display("FAIL simul_open1: got %b exp 001", OpenDoor); end
    n_checks++; if (MoveUp !== 3'b010) begin n_errors++; $display("FAIL simul_move2: got %b exp 010", MoveUp); end
    n_checks++; if (Stop !== 3'b100) begin n_errors++; $display("FAIL simul_stop3: got %b exp 100", Stop); end
    n_checks++; if (LED_HALL_UP !== 5'b00010) begin n_errors++; $display("FAIL simul_led0_clr: got %b exp 00010", LED_HALL_UP); end
    step(10); // k+11
    n_checks++; if (LCD2 !== 3'd1) begin n_errors++; $display("FAIL simul_lcd2: got %0d exp 1", LCD2); end
    n_checks++; if (OpenDoor !== 3'b010) begin n_errors++; $display("FAIL simul_open2: got %b exp 010", OpenDoor); end
    n_checks++; if (LED_HALL_UP !== 5'b00000) begin n_errors++; $display("FAIL simul_led_end: got %b exp 00000", LED_HALL_UP); end
  endtask

  task automatic test_busy_dispatch();
    do_reset();
    Car_call_signal1 = 6'b010000;
    step(1); // k
    Car_call_signal1 = '0;
    step(11); // k+11: car 1 at floor 1 heading to 4
    n_checks++; if (LCD1 !== 3'd1) begin n_errors++; $display("FAIL busy_lcd1_f1: got %0d exp 1", LCD1); end
    step(1); // k+12
    Hall_call_Down_signal = 5'b10000;
    step(1); // k+13: down[5] to car 2
    n_checks++; if (LED_HALL_DOWN !== 5'b10000) begin n_errors++; $display("FAIL busy_led_dn: got %b exp 10000", LED_HALL_DOWN); end
    Hall_call_Down_signal = '0;
    Hall_call_Up_signal = 5'b01000;
    step(1); // k+14: up[3] to car 1, car 2 starts up
    Hall_call_Up_signal = '0;
    n_checks++; if (MoveUp !== 3'b011) begin n_errors++; $display("FAIL busy_move: got %b exp 011", MoveUp); end
    n_checks++; if (Stop !== 3'b100) begin n_errors++; $display("FAIL busy_stop3: got %b exp 100", Stop); end
    step(17); // k+31
    n_checks++; if ({LCD1, OpenDoor} !== {3'd3, 3'b001}) begin n_errors++; $display("FAIL busy_stop_f3: got %h exp %h", {LCD1, OpenDoor}, {3'd3, 3'b001}); end
    n_checks++; if (LED_HALL_UP !== 5'b00000) begin n_errors++; $display("FAIL busy_led_up_clr: got %b exp 00000", LED_HALL_UP); end
    step(16); // k+47
    n_checks++; if ({LCD1, OpenDoor} !== {3'd4, 3'b001}) begin n_errors++; $display("FAIL busy_stop_f4: got %h exp %h", {LCD1, OpenDoor}, {3'd4, 3'b001}); end
    n_checks++; if (LED_Car1 !== 6'b000000) begin n_errors++; $display("FAIL busy_car1_clr: got %b exp 000000", LED_Car1); end
    step(17); // k+64
    n_checks++; if ({LCD2, OpenDoor} !== {3'd5, 3'b010}) begin n_errors++; $display("FAIL busy_car2_f5: got %h exp %h", {LCD2, OpenDoor}, {3'd5, 3'b010}); end
    n_checks++; if (LED_HALL_DOWN !== 5'b00000) begin n_errors++; $display("FAIL busy_led_dn_clr: got %b exp 00000", LED_HALL_DOWN); end
    n_checks++; if (Stop !== 3'b101) begin n_errors++; $display("FAIL busy_stop_end: got %b exp 101", Stop); end
  endtask

  task automatic test_emergency();
    do_reset();
    Car_call_signal1 = 6'b000100;
    step(1); // k
    Car_call_signal1 = '0;
    step(4); // k+4
    emergency = 3'b001;
    step(1); // k+5
    n_checks++; if ({MoveUp[1], Stop[1]} !== 2'b01) begin n_errors++; $display("FAIL emerg_halt: got %b exp 01", {MoveUp[1], Stop[1]}); end
    n_checks++; if (LED_Car1 !== 6'b000100) begin n_errors++; $display("FAIL emerg_led_kept: got %b exp 000100", LED_Car1); end
    step(3); // k+8
    n_checks++; if ({LCD1, Stop} !== {3'd0, 3'b111}) begin n_errors++; $display("FAIL emerg_frozen: got %h exp %h", {LCD1, Stop}, {3'd0, 3'b111}); end
    emergency = 3'b000;
    step(1); // k+9
    n_checks++; if (MoveUp !== 3'b001) begin n_errors++; $display("FAIL emerg_resume: got %b exp 001", MoveUp); end
    step(5); // k+14
    n_checks++; if (LCD1 !== 3'd0) begin n_errors++; $display("FAIL emerg_lcd_k14: got %0d exp 0", LCD1); end
    step(1); // k+15: four cycles later than k+11
    n_checks++; if (LCD1 !== 3'd1) begin n_errors++; $display("FAIL emerg_lcd_k15: got %0d exp 1", LCD1); end
    step(10); // k+25
    n_checks++; if ({LCD1, OpenDoor} !== {3'd2, 3'b001}) begin n_errors++; $display("FAIL emerg_arrive: got %h exp %h", {LCD1, OpenDoor}, {3'd2, 3'b001}); end
  endtask

  task automatic test_emergency_dispatch();
    do_reset();
    emergency = 3'b001;
    step(1);
    Hall_call_Up_signal = 5'b00001;
    step(1); // k: car 1 excluded, car 2 wins the tie
    Hall_call_Up_signal = '0;
    n_checks++; if (LED_HALL_UP !== 5'b00001) begin n_errors++; $display("FAIL edisp_led: got %b exp 00001", LED_HALL_UP); end
    step(1); // k+1
    n_checks++; if (OpenDoor !== 3'b010) begin n_errors++; $display("FAIL edisp_open2: got %b exp 010", OpenDoor); end
    n_checks++; if (Stop !== 3'b101) begin n_errors++; $display("FAIL edisp_stop: got %b exp 101", Stop); end
    emergency = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    Car_call_signal1 = 6'b100000;
    Hall_call_Up_signal = 5'b10000;
    step(1);
    Car_call_signal1 = '0;
    Hall_call_Up_signal = '0;
    step(12); // car 1 at floor 1, still moving
    n_checks++; if ({LCD1, MoveUp} !== {3'd1, 3'b001}) begin n_errors++; $display("FAIL midrst_pre: got %h exp %h", {LCD1, MoveUp}, {3'd1, 3'b001}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({LCD1, MoveUp, Stop} !== {3'd0, 3'b000, 3'b111}) begin n_errors++; $display("FAIL midrst_cmd: got %h exp %h", {LCD1, MoveUp, Stop}, {3'd0, 3'b000, 3'b111}); end
    n_checks++; if ({LED_Car1, LED_HALL_UP} !== 11'd0) begin n_errors++; $display("FAIL midrst_leds: got %h exp 0", {LED_Car1, LED_HALL_UP}); end
    step(1);
    rst_n = 1'b1;
    step(3);
    n_checks++; if (Stop !== 3'b111) begin n_errors++; $display("FAIL midrst_stays: got %b exp 111", Stop); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_hall();
    test_car_call_here();
    test_simultaneous();
    test_busy_dispatch();
    test_emergency();
    test_emergency_dispatch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
